// File: rtl/vga_fill_fb_if.sv
// Bus between the VGA controller / fill-command source and the 160x120 fill framebuffer.
// Carries the display read port and the rectangle-fill command handshake.
interface vga_fill_fb_if;
  logic [8:0]  row_addr;
  logic [9:0]  col_addr;
  logic        rdn;
  logic [11:0] d_out;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_x0;
  logic [6:0]  cmd_y0;
  logic [7:0]  cmd_x1;
  logic [6:0]  cmd_y1;
  logic [11:0] cmd_color;
  logic        busy;
  logic        done;

  modport slave (
    input  row_addr, col_addr, rdn, cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color,
    output d_out, cmd_ready, busy, done
  );

  modport master (
    output row_addr, col_addr, rdn, cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color,
    input  d_out, cmd_ready, busy, done
  );
endinterface

// File: rtl/vga_fill_fb.sv
// Low-resolution framebuffer (cells scaled 4x4 onto 640x480) with a zero-latency display
// read port and a rectangle-fill engine that writes one cell per vga_clk.
module vga_fill_fb #(
  parameter int H_CELLS     = 160,
  parameter int V_CELLS     = 120,
  parameter int SCALE_SHIFT = 2,
  parameter int DATA_W      = 12
) (
  input  logic          vga_clk,
  input  logic          clrn,
  vga_fill_fb_if.slave  bus
);

  localparam int         DEPTH = H_CELLS * V_CELLS;
  localparam logic [7:0] X_MAX = 8'(H_CELLS - 1);
  localparam logic [6:0] Y_MAX = 7'(V_CELLS - 1);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [7:0]        x_q, xa_q, xb_q;
  logic [6:0]        y_q, ya_q, yb_q;
  logic [DATA_W-1:0] color_q;
  logic [7:0]        xa_n, xb_n;
  logic [6:0]        ya_n, yb_n;
  logic              accept, x_last, y_last, wr_en;
  logic [14:0]       wr_idx, rd_idx;
  logic [9:0]        cx_full;
  logic [8:0]        cy_full;
  logic              rd_hit;

  function automatic logic [7:0] clamp_x(input logic [7:0] v);
    return (v > X_MAX) ? X_MAX : v;
  endfunction

  function automatic logic [6:0] clamp_y(input logic [6:0] v);
    return (v > Y_MAX) ? Y_MAX : v;
  endfunction

  // Corners are ordered first, then clamped, so a fully off-screen corner pins to the edge.
  always_comb begin
    xa_n = clamp_x((bus.cmd_x0 < bus.cmd_x1) ? bus.cmd_x0 : bus.cmd_x1);
    xb_n = clamp_x((bus.cmd_x0 < bus.cmd_x1) ? bus.cmd_x1 : bus.cmd_x0);
    ya_n = clamp_y((bus.cmd_y0 < bus.cmd_y1) ? bus.cmd_y0 : bus.cmd_y1);
    yb_n = clamp_y((bus.cmd_y0 < bus.cmd_y1) ? bus.cmd_y1 : bus.cmd_y0);
  end

  assign accept = (state == IDLE) && bus.cmd_valid;
  assign x_last = (x_q >= xb_q);
  assign y_last = (y_q >= yb_q);

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.cmd_valid) state_nxt = FILL;
      FILL:    if (x_last && y_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready = (state == IDLE);
    bus.busy      = (state == FILL);
    bus.done      = (state == DONE);
    wr_en         = (state == FILL);
  end

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      x_q <= '0;
      y_q <= '0;
    end else if (accept) begin
      x_q <= xa_n;
      y_q <= ya_n;
    end else if (state == FILL) begin
      if (!x_last) begin
        x_q <= x_q + 8'd1;
      end else begin
        x_q <= xa_q;
        if (!y_last) y_q <= y_q + 7'd1;
      end
    end
  end

  // Rectangle bounds and colour are pure data: captured on accept, never reset.
  always_ff @(posedge vga_clk) begin
    if (accept) begin
      xa_q    <= xa_n;
      xb_q    <= xb_n;
      ya_q    <= ya_n;
      yb_q    <= yb_n;
      color_q <= bus.cmd_color;
    end
  end

  assign wr_idx = 15'(y_q) * 15'(H_CELLS) + 15'(x_q);

  always_ff @(posedge vga_clk) begin
    if (wr_en) mem[wr_idx] <= color_q;
  end

  assign cx_full = bus.col_addr >> SCALE_SHIFT;
  assign cy_full = bus.row_addr >> SCALE_SHIFT;
  assign rd_hit  = !bus.rdn && (cx_full < 10'(H_CELLS)) && (cy_full < 9'(V_CELLS));
  assign rd_idx  = 15'(cy_full) * 15'(H_CELLS) + 15'(cx_full);

  // Blanking-wrap addresses never reach the array; they read as black.
  assign bus.d_out = rd_hit ? mem[rd_idx] : '0;

endmodule

// File: tb/tb_vga_fill_fb.sv
// Directed bench for vga_fill_fb: reset, clamped full fill, single cell, swapped corners,
// out-of-range reads, commands during a fill, and reset in the middle of a fill.
module tb_vga_fill_fb;
  logic vga_clk;
  logic clrn;
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  vga_fill_fb_if bus ();

  vga_fill_fb dut (
    .vga_clk (vga_clk),
    .clrn    (clrn),
    .bus     (bus)
  );

  initial vga_clk = 1'b0;
  always #20 vga_clk = ~vga_clk;

  task automatic rd_px(input int r, input int c, input logic n, output logic [11:0] v);
    bus.row_addr = 9'(r);
    bus.col_addr = 10'(c);
    bus.rdn      = n;
    #1;
    v = bus.d_out;
  endtask

  task automatic rd_cell(input int cx, input int cy, output logic [11:0] v);
    rd_px(cy * 4 + 3, cx * 4 + 1, 1'b0, v);
  endtask

  // Issue one command from IDLE; count busy cycles and the cycle (from the accept edge) of done.
  task automatic do_cmd(input int x0, input int y0, input int x1, input int y1,
                        input logic [11:0] col, output int nbusy, output int ndone);
    bus.cmd_x0    = 8'(x0);
    bus.cmd_y0    = 7'(y0);
    bus.cmd_x1    = 8'(x1);
    bus.cmd_y1    = 7'(y1);
    bus.cmd_color = col;
    bus.cmd_valid = 1'b1;
    @(posedge vga_clk); #1;
    bus.cmd_valid = 1'b0;
    nbusy = 0;
    ndone = -1;
    for (int j = 0; j < 20000; j++) begin
      if (bus.done) begin
        ndone = j;
        break;
      end
      if (bus.busy) nbusy++;
      @(posedge vga_clk); #1;
    end
  endtask

  task automatic test_reset();
    logic [11:0] v;
    clrn = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_x0 = '0; bus.cmd_y0 = '0; bus.cmd_x1 = '0; bus.cmd_y1 = '0; bus.cmd_color = '0;
    bus.row_addr = '0; bus.col_addr = '0; bus.rdn = 1'b1;
    repeat (3) @(posedge vga_clk);
    #1;
    chk_cnt++;
    if ({bus.cmd_ready, bus.busy, bus.done} !== 3'b100) $display("FAIL reset_ctrl ready/busy/done=%b want 100", {bus.cmd_ready, bus.busy, bus.done});
    else pass_cnt++;
    rd_px(0, 0, 1'b1, v);
    chk_cnt++;
    if (v !== 12'h000) $display("FAIL reset_rdn_high d_out=%h want 000", v);
    else pass_cnt++;
    clrn = 1'b1;
    @(posedge vga_clk); #1;
    chk_cnt++;
    if ({bus.cmd_ready, bus.busy, bus.done} !== 3'b100) $display("FAIL post_reset_ctrl got %b want 100", {bus.cmd_ready, bus.busy, bus.done});
    else pass_cnt++;
  endtask

  task automatic test_full_clamp();
    int nb, nd, bad;
    logic [11:0] v;
    do_cmd(0, 0, 255, 127, 12'h0F0, nb, nd);
    chk_cnt++;
    if (nb !== 19200) $display("FAIL full_busy_cycles got %0d want 19200", nb);
    else pass_cnt++;
    chk_cnt++;
    if (nd !== 19200) $display("FAIL full_done_cycle got %0d want 19200", nd);
    else pass_cnt++;
    @(posedge vga_clk); #1;
    chk_cnt++;
    if (bus.cmd_ready !== 1'b1) $display("FAIL full_ready_back got %b want 1", bus.cmd_ready);
    else pass_cnt++;
    bad = 0;
    for (int cy = 0; cy < 120; cy++)
      for (int cx = 0; cx < 160; cx++) begin
        rd_cell(cx, cy, v);
        if (v !== 12'h0F0) bad++;
      end
    chk_cnt++;
    if (bad !== 0) $display("FAIL full_all_cells bad_cells=%0d want 0", bad);
    else pass_cnt++;
    rd_px(479, 639, 1'b0, v);
    chk_cnt++;
    if (v !== 12'h0F0) $display("FAIL full_corner_479_639 got %h want 0F0", v);
    else pass_cnt++;
  endtask

  task automatic test_single_cell();
    int nb, nd, bad;
    logic [11:0] v;
    do_cmd(5, 7, 5, 7, 12'h00F, nb, nd);
    chk_cnt++;
    if (nb !== 1 || nd !== 1) $display("FAIL single_timing busy=%0d done_at=%0d want 1/1", nb, nd);
    else pass_cnt++;
    @(posedge vga_clk); #1;
    bad = 0;
    for (int r = 28; r <= 31; r++)
      for (int c = 20; c <= 23; c++) begin
        rd_px(r, c, 1'b0, v);
        if (v !== 12'h00F) bad++;
      end
    chk_cnt++;
    if (bad !== 0) $display("FAIL single_block bad_pixels=%0d want 0", bad);
    else pass_cnt++;
    rd_px(27, 20, 1'b0, v);
    chk_cnt++;
    if (v !== 12'h0F0) $display("FAIL single_neighbour got %h want 0F0", v);
    else pass_cnt++;
  endtask

  task automatic test_swapped_corners();
    int nb, nd, bad;
    logic [11:0] v;
    do_cmd(10, 4, 3, 2, 12'hF00, nb, nd);
    chk_cnt++;
    if (nb !== 24 || nd !== 24) $display("FAIL swap_timing busy=%0d done_at=%0d want 24/24", nb, nd);
    else pass_cnt++;
    @(posedge vga_clk); #1;
    bad = 0;
    for (int cy = 2; cy <= 4; cy++)
      for (int cx = 3; cx <= 10; cx++) begin
        rd_cell(cx, cy, v);
        if (v !== 12'hF00) bad++;
      end
    chk_cnt++;
    if (bad !== 0) $display("FAIL swap_rect bad_cells=%0d want 0", bad);
    else pass_cnt++;
    rd_cell(11, 2, v);
    chk_cnt++;
    if (v !== 12'h0F0) $display("FAIL swap_right_neighbour got %h want 0F0", v);
    else pass_cnt++;
    rd_cell(2, 3, v);
    chk_cnt++;
    if (v !== 12'h0F0) $display("FAIL swap_left_neighbour got %h want 0F0", v);
    else pass_cnt++;
  endtask

  task automatic test_out_of_range();
    logic [11:0] v;
    rd_px(10, 14, 1'b1, v);
    chk_cnt++;
    if (v !== 12'h000) $display("FAIL oor_rdn_high got %h want 000", v);
    else pass_cnt++;
    rd_px(500, 10, 1'b0, v);
    chk_cnt++;
    if (v !== 12'h000) $display("FAIL oor_row500 got %h want 000", v);
    else pass_cnt++;
    rd_px(10, 700, 1'b0, v);
    chk_cnt++;
    if (v !== 12'h000) $display("FAIL oor_col700 got %h want 000", v);
    else pass_cnt++;
    rd_px(480, 0, 1'b0, v);
    chk_cnt++;
    if (v !== 12'h000) $display("FAIL oor_row480 got %h want 000", v);
    else pass_cnt++;
    rd_px(0, 640, 1'b0, v);
    chk_cnt++;
    if (v !== 12'h000) $display("FAIL oor_col640 got %h want 000", v);
    else pass_cnt++;
  endtask

  task automatic test_cmd_during_fill();
    int nb, nd, bad_ready, j;
    logic [11:0] v;
    bus.cmd_x0 = 8'd20; bus.cmd_y0 = 7'd20; bus.cmd_x1 = 8'd21; bus.cmd_y1 = 7'd21;
    bus.cmd_color = 12'h111;
    bus.cmd_valid = 1'b1;
    @(posedge vga_clk); #1;
    bus.cmd_x0 = 8'd30; bus.cmd_y0 = 7'd30; bus.cmd_x1 = 8'd30; bus.cmd_y1 = 7'd30;
    bus.cmd_color = 12'h222;
    bad_ready = 0;
    nb = 0;
    nd = -1;
    for (j = 0; j < 100; j++) begin
      if (bus.cmd_ready !== 1'b0) bad_ready++;
      if (bus.done) begin
        nd = j;
        break;
      end
      if (bus.busy) nb++;
      @(posedge vga_clk); #1;
    end
    bus.cmd_valid = 1'b0;
    chk_cnt++;
    if (bad_ready !== 0) $display("FAIL hold_ready_low bad_cycles=%0d want 0", bad_ready);
    else pass_cnt++;
    chk_cnt++;
    if (nb !== 4 || nd !== 4) $display("FAIL hold_timing busy=%0d done_at=%0d want 4/4", nb, nd);
    else pass_cnt++;
    @(posedge vga_clk); #1;
    rd_cell(21, 21, v);
    chk_cnt++;
    if (v !== 12'h111) $display("FAIL hold_first_rect got %h want 111", v);
    else pass_cnt++;
    rd_cell(30, 30, v);
    chk_cnt++;
    if (v !== 12'h0F0) $display("FAIL hold_not_queued got %h want 0F0", v);
    else pass_cnt++;
    do_cmd(30, 30, 30, 30, 12'h222, nb, nd);
    @(posedge vga_clk); #1;
    rd_cell(30, 30, v);
    chk_cnt++;
    if (v !== 12'h222 || nd !== 1) $display("FAIL second_cmd cell=%h done_at=%0d want 222/1", v, nd);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_fill();
    int bad;
    logic [11:0] v;
    bus.cmd_x0 = 8'd40; bus.cmd_y0 = 7'd40; bus.cmd_x1 = 8'd59; bus.cmd_y1 = 7'd59;
    bus.cmd_color = 12'hABC;
    bus.cmd_valid = 1'b1;
    @(posedge vga_clk); #1;
    bus.cmd_valid = 1'b0;
    repeat (10) @(posedge vga_clk);
    #1;
    clrn = 1'b0;
    #1;
    chk_cnt++;
    if ({bus.cmd_ready, bus.busy, bus.done} !== 3'b100) $display("FAIL midrst_ctrl got %b want 100", {bus.cmd_ready, bus.busy, bus.done});
    else pass_cnt++;
    @(posedge vga_clk); #1;
    clrn = 1'b1;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      if (bus.done !== 1'b0) bad++;
      @(posedge vga_clk); #1;
    end
    chk_cnt++;
    if (bad !== 0) $display("FAIL midrst_no_done done_cycles=%0d want 0", bad);
    else pass_cnt++;
    bad = 0;
    for (int cx = 40; cx <= 49; cx++) begin
      rd_cell(cx, 40, v);
      if (v !== 12'hABC) bad++;
    end
    chk_cnt++;
    if (bad !== 0) $display("FAIL midrst_written bad_cells=%0d want 0", bad);
    else pass_cnt++;
    rd_cell(50, 40, v);
    chk_cnt++;
    if (v !== 12'h0F0) $display("FAIL midrst_cell_50_40 got %h want 0F0", v);
    else pass_cnt++;
    rd_cell(40, 41, v);
    chk_cnt++;
    if (v !== 12'h0F0) $display("FAIL midrst_cell_40_41 got %h want 0F0", v);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_full_clamp();
    test_single_cell();
    test_swapped_corners();
    test_out_of_range();
    test_cmd_during_fill();
    test_reset_mid_fill();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
